// File: rtl/gcm_ingress_parser.sv
`default_nettype none
// ============================================================================
// Module      : gcm_ingress_parser
// Description : GCM front-end frame parser. Latches LEN/KEY/IV as sideband
//               config and forwards AAD/payload beats through an output slice.
// Revision    : 1.0 - initial release
// ============================================================================
module gcm_ingress_parser #(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_BEATS  = 2,
    parameter int CNT_W      = 32
) (
    input  logic                      s_clk,
    input  logic                      s_areset,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [1:0]                m_axis_tuser,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic [KEY_BEATS*128-1:0]  key_out,
    output logic [95:0]               iv_out,
    output logic [63:0]               aad_bitlen,
    output logic [63:0]               pt_bitlen,
    output logic                      cfg_valid,
    output logic                      frame_done,
    output logic                      err_tlast
);

    localparam int c_KEEP_W = DATA_WIDTH / 8;
    localparam int c_KEY_W  = KEY_BEATS * 128;
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_KEY_LAST = CNT_W'(KEY_BEATS - 1);

    typedef enum logic [2:0] {
        ST_LEN = 3'd0,
        ST_KEY = 3'd1,
        ST_AAD = 3'd2,
        ST_IV  = 3'd3,
        ST_PAY = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [CNT_W-1:0]        r_aad_beats;
    logic [CNT_W-1:0]        r_pay_beats;
    logic [63:0]             r_aad_bitlen;
    logic [63:0]             r_pt_bitlen;
    logic [c_KEY_W-1:0]      r_key;
    logic [c_KEY_W-1:0]      w_key_shift;
    logic [95:0]             r_iv;
    logic                    r_cfg_valid;
    logic                    r_frame_done;
    logic                    r_err_tlast;
    logic [DATA_WIDTH-1:0]   r_m_tdata;
    logic [c_KEEP_W-1:0]     r_m_tkeep;
    logic [1:0]              r_m_tuser;
    logic                    r_m_tvalid;
    logic                    r_m_tlast;

    logic                    w_fwd_state;
    logic                    w_out_free;
    logic                    w_tready;
    logic                    w_accept;
    logic                    w_sec_last;
    logic                    w_final;
    logic                    w_early;
    logic                    w_missing;
    logic [6:0]              w_rem;
    logic [4:0]              w_nbytes;
    logic [c_KEEP_W-1:0]     w_keep;
    logic                    w_mlast;
    logic [CNT_W-1:0]        w_len_aad_beats;
    logic [CNT_W-1:0]        w_len_pay_beats;

    assign w_fwd_state = (r_state == ST_AAD) || (r_state == ST_PAY);
    assign w_out_free  = !r_m_tvalid || m_axis_tready;
    // Reset is folded in so the port reads 0 while reset is held.
    assign w_tready    = !s_areset && (w_fwd_state ? w_out_free : 1'b1);
    assign w_accept    = s_axis_tvalid && w_tready;

    // Beat counts are ceil(bitlen/128) on the low CNT_W+7 bits.
    assign w_len_aad_beats = s_axis_tdata[71 +: CNT_W]
                           + {{(CNT_W-1){1'b0}}, |s_axis_tdata[70:64]};
    assign w_len_pay_beats = s_axis_tdata[7 +: CNT_W]
                           + {{(CNT_W-1){1'b0}}, |s_axis_tdata[6:0]};

    generate
        if (KEY_BEATS == 1) begin : g_key_single
            assign w_key_shift = s_axis_tdata[127:0];
        end else begin : g_key_multi
            assign w_key_shift = {r_key[c_KEY_W-129:0], s_axis_tdata[127:0]};
        end
    endgenerate

    always_ff @(posedge s_clk or posedge s_areset) begin
        if (s_areset) begin
            r_state <= ST_LEN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sec_last  = 1'b0;
        w_keep      = '1;
        w_mlast     = 1'b0;
        w_rem       = (r_state == ST_AAD) ? r_aad_bitlen[6:0] : r_pt_bitlen[6:0];
        w_nbytes    = {1'b0, w_rem[6:3]} + {4'b0, |w_rem[2:0]};

        case (r_state)
            ST_LEN:  w_sec_last = 1'b1;
            ST_KEY:  w_sec_last = (r_cnt == c_KEY_LAST);
            ST_AAD:  w_sec_last = (r_cnt == r_aad_beats - c_ONE);
            ST_IV:   w_sec_last = 1'b1;
            ST_PAY:  w_sec_last = (r_cnt == r_pay_beats - c_ONE);
            default: w_sec_last = 1'b0;
        endcase

        w_final   = ((r_state == ST_IV) && (r_pay_beats == '0))
                 || ((r_state == ST_PAY) && w_sec_last);
        w_early   = w_accept && s_axis_tlast && !w_final;
        w_missing = w_accept && !s_axis_tlast && w_final;

        if (w_sec_last && (w_rem != 7'd0)) begin
            w_keep = ~({c_KEEP_W{1'b1}} >> w_nbytes);
        end
        w_mlast = w_early
               || ((r_state == ST_PAY) && w_sec_last)
               || ((r_state == ST_AAD) && w_sec_last && (r_pay_beats == '0));

        if (w_accept) begin
            w_cnt_nxt = w_sec_last ? '0 : r_cnt + c_ONE;
            case (r_state)
                ST_LEN:  w_state_nxt = ST_KEY;
                ST_KEY:  if (w_sec_last) w_state_nxt = (r_aad_beats != '0) ? ST_AAD : ST_IV;
                ST_AAD:  if (w_sec_last) w_state_nxt = ST_IV;
                ST_IV:   w_state_nxt = (r_pay_beats != '0) ? ST_PAY : ST_LEN;
                ST_PAY:  if (w_sec_last) w_state_nxt = ST_LEN;
                default: w_state_nxt = ST_LEN;
            endcase
            if (w_early) begin
                w_state_nxt = ST_LEN;
                w_cnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge s_clk or posedge s_areset) begin
        if (s_areset) begin
            r_aad_beats  <= '0;
            r_pay_beats  <= '0;
            r_aad_bitlen <= '0;
            r_pt_bitlen  <= '0;
            r_key        <= '0;
            r_iv         <= '0;
            r_cfg_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_tlast  <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tkeep    <= '0;
            r_m_tuser    <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_final;
            r_err_tlast  <= w_early || w_missing;

            if (w_accept) begin
                case (r_state)
                    ST_LEN: begin
                        r_aad_bitlen <= s_axis_tdata[127:64];
                        r_pt_bitlen  <= s_axis_tdata[63:0];
                        r_aad_beats  <= w_len_aad_beats;
                        r_pay_beats  <= w_len_pay_beats;
                        r_cfg_valid  <= 1'b0;
                    end
                    ST_KEY:  r_key <= w_key_shift;
                    ST_IV: begin
                        r_iv        <= s_axis_tdata[95:0];
                        r_cfg_valid <= 1'b1;
                    end
                    default: ;
                endcase
                if (w_early) begin
                    r_cfg_valid <= 1'b0;
                end
            end

            // Slice only reloads when it is empty or draining this cycle.
            if (w_accept && w_fwd_state) begin
                r_m_tdata  <= s_axis_tdata;
                r_m_tkeep  <= w_keep;
                r_m_tuser  <= (r_state == ST_AAD) ? 2'b01 : 2'b10;
                r_m_tlast  <= w_mlast;
                r_m_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign s_axis_tready = w_tready;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign key_out       = r_key;
    assign iv_out        = r_iv;
    assign aad_bitlen    = r_aad_bitlen;
    assign pt_bitlen     = r_pt_bitlen;
    assign cfg_valid     = r_cfg_valid;
    assign frame_done    = r_frame_done;
    assign err_tlast     = r_err_tlast;

endmodule
`default_nettype wire

// File: tb/tb_gcm_ingress_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcm_ingress_parser
// Description : Self-checking bench for gcm_ingress_parser against a
//               frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcm_ingress_parser;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic [1:0]   u;
        logic         l;
    } beat_t;

    logic         s_clk = 1'b0;
    logic         s_areset = 1'b1;
    logic [127:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         sel2 = 1'b0;
    logic         m_tready;
    logic         m2_tready = 1'b1;
    logic         stall_mode = 1'b0;
    int           stall_cnt;

    logic         tv1, tv2, tready1, tready2, tready_sel;
    logic [127:0] m_tdata, m2_tdata;
    logic [15:0]  m_tkeep, m2_tkeep;
    logic [1:0]   m_tuser, m2_tuser;
    logic         m_tvalid, m_tlast, m2_tvalid, m2_tlast;
    logic [255:0] key_out;
    logic [127:0] key2;
    logic [95:0]  iv_out, iv2;
    logic [63:0]  aad_bitlen, pt_bitlen, aadlen2, ptlen2;
    logic         cfg_valid, frame_done, err_tlast, cfg2, done2, err2;

    int n_vec = 0, n_err = 0;
    int n_done = 0, n_errp = 0, exp_done = 0, exp_errp = 0;
    int n_done2 = 0, n_err2 = 0, n_out2 = 0;

    beat_t        exp_q[$];
    logic [15:0]  obs_keep[$];
    logic [1:0]   obs_user[$];
    logic         obs_last[$];

    logic [127:0] g_key[2];
    logic [95:0]  g_iv;
    logic [127:0] g_aad[$];
    logic [127:0] g_pay[$];

    assign tv1 = s_tvalid & ~sel2;
    assign tv2 = s_tvalid & sel2;
    assign tready_sel = sel2 ? tready2 : tready1;

    always #5 s_clk = ~s_clk;

    gcm_ingress_parser #(.DATA_WIDTH(128), .KEY_BEATS(2), .CNT_W(32)) u_dut (
        .s_clk(s_clk), .s_areset(s_areset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(tv1), .s_axis_tlast(s_tlast),
        .s_axis_tready(tready1),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .key_out(key_out), .iv_out(iv_out), .aad_bitlen(aad_bitlen), .pt_bitlen(pt_bitlen),
        .cfg_valid(cfg_valid), .frame_done(frame_done), .err_tlast(err_tlast)
    );

    gcm_ingress_parser #(.DATA_WIDTH(128), .KEY_BEATS(1), .CNT_W(32)) u_dut_k1 (
        .s_clk(s_clk), .s_areset(s_areset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(tv2), .s_axis_tlast(s_tlast),
        .s_axis_tready(tready2),
        .m_axis_tdata(m2_tdata), .m_axis_tkeep(m2_tkeep), .m_axis_tuser(m2_tuser),
        .m_axis_tvalid(m2_tvalid), .m_axis_tlast(m2_tlast), .m_axis_tready(m2_tready),
        .key_out(key2), .iv_out(iv2), .aad_bitlen(aadlen2), .pt_bitlen(ptlen2),
        .cfg_valid(cfg2), .frame_done(done2), .err_tlast(err2)
    );

    // Downstream ready: always high, or alternating high/low runs of 1..31 cycles.
    initial begin
        m_tready  = 1'b1;
        stall_cnt = 0;
        forever begin
            @(posedge s_clk);
            #2;
            if (!stall_mode) begin
                m_tready = 1'b1;
            end else if (stall_cnt > 0) begin
                stall_cnt--;
            end else begin
                m_tready  = ~m_tready;
                stall_cnt = int'($urandom_range(1, 31)) - 1;
            end
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected keep from the section length: full beats except a partial last one,
    // where only the leading ceil(rem/8) bytes (MS end) are valid.
    function automatic logic [15:0] exp_keep(input logic [63:0] bits, input int idx);
        int beats, rem, nb;
        logic [15:0] k;
        beats = int'((bits + 64'd127) / 64'd128);
        rem   = int'(bits % 64'd128);
        k     = 16'hFFFF;
        if (idx == beats - 1 && rem != 0) begin
            nb = (rem + 7) / 8;
            for (int b = 0; b < 16; b++) k[b] = (b >= 16 - nb);
        end
        return k;
    endfunction

    task automatic run_monitor();
        logic [147:0] prev_bus;
        logic [147:0] cur_bus;
        bit           prev_stall;
        beat_t        e;
        prev_stall = 1'b0;
        prev_bus   = '0;
        forever begin
            @(negedge s_clk);
            cur_bus = {m_tdata, m_tkeep, m_tuser, m_tlast, m_tvalid};
            if (s_areset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_vec++;
                    if (cur_bus !== prev_bus) begin
                        n_err++;
                        $display("FAIL stall_hold got %h expected %h", cur_bus, prev_bus);
                    end
                end
                if (m_tvalid && m_tready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_beat got %h expected none", cur_bus);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_tdata, m_tkeep, m_tuser, m_tlast} !== e) begin
                            n_err++;
                            $display("FAIL out_beat got %h expected %h",
                                     {m_tdata, m_tkeep, m_tuser, m_tlast}, e);
                        end
                    end
                    obs_keep.push_back(m_tkeep);
                    obs_user.push_back(m_tuser);
                    obs_last.push_back(m_tlast);
                end
                prev_stall = m_tvalid && !m_tready;
                prev_bus   = cur_bus;
                if (frame_done) n_done++;
                if (err_tlast)  n_errp++;
                if (done2)      n_done2++;
                if (err2)       n_err2++;
                if (m2_tvalid)  n_out2++;
            end
        end
    endtask

    task automatic send_beat(input logic [127:0] d, input logic l);
        int t;
        @(negedge s_clk);
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        t = 0;
        #1;
        while (!tready_sel && t < 500) begin
            @(negedge s_clk);
            #1;
            t++;
        end
        if (t >= 500) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout got tready=0 expected 1 within 500 cycles");
        end
        @(posedge s_clk);
    endtask

    task automatic end_frame();
        @(negedge s_clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge s_clk);
            t++;
        end
        if (t >= 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL drain got %0d beats pending expected 0", exp_q.size());
        end
        repeat (3) @(negedge s_clk);
    endtask

    task automatic set_random_data(input int na, input int np);
        g_key[0] = rand128();
        g_key[1] = rand128();
        g_iv     = {$urandom, $urandom, $urandom};
        g_aad.delete();
        g_pay.delete();
        for (int i = 0; i < na; i++) g_aad.push_back(rand128());
        for (int i = 0; i < np; i++) g_pay.push_back(rand128());
    endtask

    // tlast_at: -1 = tlast on the true final beat, -2 = never, >=0 = that frame beat.
    // stop_after: >=0 sends only that many beats (abandoned frame).
    task automatic send_frame(input logic [63:0] aad_bits, input logic [63:0] pt_bits,
                              input int tlast_at, input int stop_after, input int kb);
        logic [127:0] fd[$];
        int           fk[$];
        int           fi[$];
        int           na, np, fin;
        bit           early, l;
        beat_t        e;
        na = int'((aad_bits + 64'd127) / 64'd128);
        np = int'((pt_bits + 64'd127) / 64'd128);
        fd.push_back({aad_bits, pt_bits}); fk.push_back(0); fi.push_back(0);
        for (int k = 0; k < kb; k++) begin fd.push_back(g_key[k]); fk.push_back(1); fi.push_back(k); end
        for (int i = 0; i < na; i++) begin fd.push_back(g_aad[i]); fk.push_back(2); fi.push_back(i); end
        fd.push_back({32'h0, g_iv}); fk.push_back(3); fi.push_back(0);
        for (int i = 0; i < np; i++) begin fd.push_back(g_pay[i]); fk.push_back(4); fi.push_back(i); end
        fin   = fd.size() - 1;
        early = (tlast_at >= 0) && (tlast_at != fin);
        for (int j = 0; j <= fin; j++) begin
            if (stop_after >= 0 && j >= stop_after) break;
            if (tlast_at == -1)      l = (j == fin);
            else if (tlast_at == -2) l = 1'b0;
            else                     l = (j == tlast_at);
            if (fk[j] == 2 || fk[j] == 4) begin
                e.d = fd[j];
                e.k = exp_keep((fk[j] == 2) ? aad_bits : pt_bits, fi[j]);
                e.u = (fk[j] == 2) ? 2'b01 : 2'b10;
                e.l = (early && j == tlast_at)
                   || (fk[j] == 4 && fi[j] == np - 1)
                   || (fk[j] == 2 && fi[j] == na - 1 && np == 0);
                exp_q.push_back(e);
            end
            send_beat(fd[j], l);
            if (early && j == tlast_at) break;
        end
        if (stop_after < 0 && kb == 2) begin
            if (early) begin
                exp_errp++;
            end else begin
                exp_done++;
                if (tlast_at == -2) exp_errp++;
            end
        end
    endtask

    task automatic check_counts(input string tag);
        n_vec++;
        if (n_done !== exp_done) begin
            n_err++;
            $display("FAIL %s frame_done_count got %0d expected %0d", tag, n_done, exp_done);
        end
        n_vec++;
        if (n_errp !== exp_errp) begin
            n_err++;
            $display("FAIL %s err_tlast_count got %0d expected %0d", tag, n_errp, exp_errp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        n_vec++;
        if ({m_tdata, m_tkeep, m_tuser, m_tvalid, m_tlast} !== '0) begin
            n_err++;
            $display("FAIL %s m_axis got %h expected 0", tag,
                     {m_tdata, m_tkeep, m_tuser, m_tvalid, m_tlast});
        end
        n_vec++;
        if ({key_out, iv_out, aad_bitlen, pt_bitlen} !== '0) begin
            n_err++;
            $display("FAIL %s cfg_regs got %h expected 0", tag, {iv_out, aad_bitlen, pt_bitlen});
        end
        n_vec++;
        if ({cfg_valid, frame_done, err_tlast, tready1} !== 4'b0) begin
            n_err++;
            $display("FAIL %s flags got %b expected 0000", tag,
                     {cfg_valid, frame_done, err_tlast, tready1});
        end
    endtask

    task automatic test_reset();
        s_areset = 1'b1;
        repeat (3) @(negedge s_clk);
        check_zero_outputs("reset");
        s_areset = 1'b0;
        @(negedge s_clk);
        n_vec++;
        if (tready1 !== 1'b1 || m_tvalid !== 1'b0 || cfg_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release got tready=%b mvalid=%b cfg=%b expected 1 0 0",
                     tready1, m_tvalid, cfg_valid);
        end
    endtask

    task automatic test_gcm_vector();
        logic [15:0] ek[6] = '{16'hFFFF, 16'hF000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        logic [1:0]  eu[6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
        logic        el[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int done0;
        g_key[0] = 128'hfeffe9928665731c6d6a8f9467308308;
        g_key[1] = 128'hfeffe9928665731c6d6a8f9467308308;
        g_iv     = 96'hcafebabefacedbaddecaf888;
        g_aad.delete();
        g_pay.delete();
        g_aad.push_back(128'hfeedfacedeadbeeffeedfacedeadbeef);
        g_aad.push_back(128'habaddad2000000000000000000000000);
        g_pay.push_back(128'hd9313225f88406e5a55909c5aff5269a);
        g_pay.push_back(128'h86a7a9531534f7da2e4c303d8a318a72);
        g_pay.push_back(128'h1c3c0c95956809532fcf0e2449a6b525);
        g_pay.push_back(128'hb16aedf5aa0de657ba637b391aafd255);
        obs_keep.delete(); obs_user.delete(); obs_last.delete();
        done0 = n_done;
        send_frame(64'hA0, 64'd512, -1, -1, 2);
        end_frame();
        wait_drain();
        n_vec++;
        if (obs_keep.size() !== 6) begin
            n_err++;
            $display("FAIL gcm_beat_count got %0d expected 6", obs_keep.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if ({obs_keep[i], obs_user[i], obs_last[i]} !== {ek[i], eu[i], el[i]}) begin
                    n_err++;
                    $display("FAIL gcm_beat%0d got keep=%h user=%b last=%b expected keep=%h user=%b last=%b",
                             i, obs_keep[i], obs_user[i], obs_last[i], ek[i], eu[i], el[i]);
                end
            end
        end
        n_vec++;
        if (cfg_valid !== 1'b1 || key_out !== {g_key[0], g_key[1]} || iv_out !== g_iv) begin
            n_err++;
            $display("FAIL gcm_cfg got cfg=%b iv=%h expected cfg=1 iv=%h", cfg_valid, iv_out, g_iv);
        end
        n_vec++;
        if (aad_bitlen !== 64'hA0 || pt_bitlen !== 64'd512) begin
            n_err++;
            $display("FAIL gcm_lens got %h/%h expected a0/200", aad_bitlen, pt_bitlen);
        end
        n_vec++;
        if (n_done - done0 !== 1) begin
            n_err++;
            $display("FAIL gcm_done_pulses got %0d expected 1", n_done - done0);
        end
        check_counts("gcm");
    endtask

    task automatic test_no_aad();
        set_random_data(0, 2);
        obs_keep.delete(); obs_user.delete(); obs_last.delete();
        send_frame(64'd0, 64'd200, -1, -1, 2);
        end_frame();
        wait_drain();
        n_vec++;
        if (obs_keep.size() !== 2) begin
            n_err++;
            $display("FAIL noaad_beat_count got %0d expected 2", obs_keep.size());
        end else begin
            n_vec++;
            if ({obs_keep[0], obs_keep[1], obs_user[0], obs_user[1], obs_last[0], obs_last[1]}
                !== {16'hFFFF, 16'hFF80, 2'b10, 2'b10, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL noaad_beats got keep=%h,%h last=%b%b expected ffff,ff80 last=01",
                         obs_keep[0], obs_keep[1], obs_last[0], obs_last[1]);
            end
        end
        check_counts("noaad");
    endtask

    task automatic test_back_to_back();
        int lasts;
        logic [127:0] k0, k1;
        logic [95:0]  iv;
        stall_mode = 1'b1;
        obs_keep.delete(); obs_user.delete(); obs_last.delete();
        g_key[0] = 128'hfeffe9928665731c6d6a8f9467308308;
        g_key[1] = 128'hfeffe9928665731c6d6a8f9467308308;
        g_iv     = 96'hcafebabefacedbaddecaf888;
        send_frame(64'hA0, 64'd512, -1, -1, 2);
        set_random_data(2, 4);
        k0 = g_key[0]; k1 = g_key[1]; iv = g_iv;
        send_frame(64'hA0, 64'd512, -1, -1, 2);
        end_frame();
        @(negedge s_clk);
        n_vec++;
        if (key_out !== {k0, k1} || iv_out !== iv || cfg_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_cfg2 got iv=%h cfg=%b expected iv=%h cfg=1", iv_out, cfg_valid, iv);
        end
        wait_drain();
        lasts = 0;
        foreach (obs_last[i]) lasts += int'(obs_last[i]);
        n_vec++;
        if (obs_last.size() !== 12 || lasts !== 2) begin
            n_err++;
            $display("FAIL b2b_beats got %0d beats %0d tlast expected 12 beats 2 tlast",
                     obs_last.size(), lasts);
        end
        check_counts("b2b");
        stall_mode = 1'b0;
    endtask

    task automatic test_tlast_errors();
        set_random_data(0, 4);
        obs_last.delete();
        send_frame(64'd0, 64'd512, 5, -1, 2);
        end_frame();
        wait_drain();
        n_vec++;
        if (cfg_valid !== 1'b0) begin
            n_err++;
            $display("FAIL early_cfg got %b expected 0", cfg_valid);
        end
        n_vec++;
        if (obs_last.size() !== 2) begin
            n_err++;
            $display("FAIL early_beats got %0d expected 2", obs_last.size());
        end
        check_counts("early");
        set_random_data(1, 3);
        send_frame(64'd100, 64'd300, -1, -1, 2);
        end_frame();
        wait_drain();
        n_vec++;
        if (cfg_valid !== 1'b1 || aad_bitlen !== 64'd100 || pt_bitlen !== 64'd300 || iv_out !== g_iv) begin
            n_err++;
            $display("FAIL after_early_cfg got cfg=%b lens=%0d/%0d expected 1 100/300",
                     cfg_valid, aad_bitlen, pt_bitlen);
        end
        check_counts("after_early");
        set_random_data(1, 2);
        send_frame(64'd128, 64'd256, -2, -1, 2);
        end_frame();
        wait_drain();
        n_vec++;
        if (cfg_valid !== 1'b1) begin
            n_err++;
            $display("FAIL notlast_cfg got %b expected 1", cfg_valid);
        end
        check_counts("notlast");
    endtask

    task automatic test_reset_mid_payload();
        set_random_data(2, 4);
        send_frame(64'hA0, 64'd512, -1, 7, 2);
        #3;
        s_areset = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        exp_q.delete();
        repeat (2) @(negedge s_clk);
        s_areset = 1'b0;
        @(negedge s_clk);
        test_gcm_vector();
    endtask

    task automatic test_random_frames();
        logic [63:0] ab, pb;
        stall_mode = 1'b1;
        for (int f = 0; f < 8; f++) begin
            ab = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 700));
            pb = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 900));
            set_random_data(int'((ab + 127) / 128), int'((pb + 127) / 128));
            send_frame(ab, pb, -1, -1, 2);
        end
        end_frame();
        wait_drain();
        n_vec++;
        if (aad_bitlen !== ab || pt_bitlen !== pb || iv_out !== g_iv || key_out !== {g_key[0], g_key[1]}) begin
            n_err++;
            $display("FAIL rand_cfg got lens=%0d/%0d expected %0d/%0d", aad_bitlen, pt_bitlen, ab, pb);
        end
        check_counts("random");
        stall_mode = 1'b0;
    endtask

    task automatic test_key128();
        int done0;
        done0 = n_done2;
        sel2  = 1'b1;
        set_random_data(0, 0);
        send_frame(64'd0, 64'd0, -1, -1, 1);
        end_frame();
        sel2 = 1'b0;
        repeat (3) @(negedge s_clk);
        n_vec++;
        if (key2 !== g_key[0] || iv2 !== g_iv || cfg2 !== 1'b1) begin
            n_err++;
            $display("FAIL k1_cfg got key=%h cfg=%b expected key=%h cfg=1", key2, cfg2, g_key[0]);
        end
        n_vec++;
        if (n_done2 - done0 !== 1 || n_err2 !== 0 || n_out2 !== 0) begin
            n_err++;
            $display("FAIL k1_events got done=%0d err=%0d beats=%0d expected 1 0 0",
                     n_done2 - done0, n_err2, n_out2);
        end
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_gcm_vector();
        test_no_aad();
        test_back_to_back();
        test_tlast_errors();
        test_reset_mid_payload();
        test_random_frames();
        test_key128();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
